// File: rtl/axis_rx_frame_checker_if.sv
// Byte-wide receive AXI-Stream bundle (no tready) feeding the frame checker.
interface axis_rx_frame_checker_if #(
   parameter int unsigned USER_WIDTH = 1
);
   logic [7:0]            tdata;
   logic                  tvalid;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/axis_rx_frame_checker.sv
// Receive-side test-frame checker: frame classification, saturating stats, sequence-loss accounting.
// Optional payload pattern compare enabled by defining RX_CHECKER_PAYLOAD_EN.
module axis_rx_frame_checker #(
   parameter int unsigned USER_WIDTH     = 1,
   parameter logic [15:0] ETHERTYPE      = 16'h88B5,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned BYTE_CNT_WIDTH = 48
) (
   input  logic                      clk,
   input  logic                      rst_n,
   axis_rx_frame_checker_if.slave    s_axis,
   input  logic                      clear,
   output logic                      frame_done,
   output logic                      frame_good,
   output logic [CNT_WIDTH-1:0]      rx_frames,
   output logic [BYTE_CNT_WIDTH-1:0] rx_bytes,
   output logic [CNT_WIDTH-1:0]      err_frames,
   output logic [CNT_WIDTH-1:0]      other_frames,
   output logic [CNT_WIDTH-1:0]      good_frames,
   output logic [BYTE_CNT_WIDTH-1:0] good_bytes,
   output logic [CNT_WIDTH-1:0]      bad_payload,
   output logic [CNT_WIDTH-1:0]      lost_frames,
   output logic [CNT_WIDTH-1:0]      ooo_frames,
   output logic                      seq_synced
);

   localparam int unsigned IDX_W   = 16;
   localparam int unsigned SEQ_W   = 32;
   localparam int unsigned BCW1    = BYTE_CNT_WIDTH + 1;
   localparam int unsigned LOST_W  = ((CNT_WIDTH > SEQ_W) ? CNT_WIDTH : SEQ_W) + 1;
   localparam logic [IDX_W-1:0] IDX_MAX = '1;
   localparam logic [IDX_W-1:0] MIN_LEN = IDX_W'(18);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   localparam logic [1:0] ST_HDR = 2'd0;
   localparam logic [1:0] ST_SEQ = 2'd1;
   localparam logic [1:0] ST_PAY = 2'd2;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a);
      return (a == CNT_MAX) ? a : a + CNT_WIDTH'(1);
   endfunction

   function automatic logic [BYTE_CNT_WIDTH-1:0] sat_add_bytes(
      input logic [BYTE_CNT_WIDTH-1:0] a, input logic [IDX_W-1:0] b);
      logic [BCW1-1:0] s;
      s = BCW1'(a) + BCW1'(b);
      return s[BCW1-1] ? '1 : s[BYTE_CNT_WIDTH-1:0];
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add_lost(
      input logic [CNT_WIDTH-1:0] a, input logic [SEQ_W-1:0] b);
      logic [LOST_W-1:0] s;
      s = LOST_W'(a) + LOST_W'(b);
      return (s > LOST_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(s);
   endfunction

   // Parser state
   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      etype_q, etype_d;
   logic [SEQ_W-1:0] seq_q, seq_d;

   // Accounting state
   logic                      frame_done_q, frame_done_d;
   logic                      frame_good_q, frame_good_d;
   logic [CNT_WIDTH-1:0]      rx_frames_q, rx_frames_d;
   logic [BYTE_CNT_WIDTH-1:0] rx_bytes_q, rx_bytes_d;
   logic [CNT_WIDTH-1:0]      err_frames_q, err_frames_d;
   logic [CNT_WIDTH-1:0]      other_frames_q, other_frames_d;
   logic [CNT_WIDTH-1:0]      good_frames_q, good_frames_d;
   logic [BYTE_CNT_WIDTH-1:0] good_bytes_q, good_bytes_d;
   logic [CNT_WIDTH-1:0]      lost_frames_q, lost_frames_d;
   logic [CNT_WIDTH-1:0]      ooo_frames_q, ooo_frames_d;
   logic                      seq_synced_q, seq_synced_d;
   logic [SEQ_W-1:0]          expected_q, expected_d;

   logic [USER_WIDTH-1:0] tuser_c;
   logic                  beat_c, last_c, frame_err_c;
   logic [IDX_W-1:0]      len_c;
   logic [SEQ_W-1:0]      seq_cur_c, seq_diff_c;
   logic                  is_other_c, mismatch_c;

   assign tuser_c     = s_axis.tuser;
   assign frame_err_c = tuser_c[0];
   assign beat_c      = s_axis.tvalid;
   assign last_c      = s_axis.tvalid & s_axis.tlast;
   assign len_c       = (idx_q == IDX_MAX) ? IDX_MAX : idx_q + IDX_W'(1);
   // The final sequence byte may arrive on the tlast beat of an 18-byte frame
   assign seq_cur_c   = (state_q == ST_SEQ) ? {seq_q[SEQ_W-9:0], s_axis.tdata} : seq_q;
   assign is_other_c  = (len_c < MIN_LEN) || (etype_q != ETHERTYPE);

`ifdef RX_CHECKER_PAYLOAD_EN
   logic [7:0]           exp_byte_q, exp_byte_d;
   logic                 mismatch_q, mismatch_d;
   logic [CNT_WIDTH-1:0] bad_payload_q, bad_payload_d;

   // Running expected payload byte, seeded from seq[7:0] as it arrives
   always_comb begin
      exp_byte_d = exp_byte_q;
      mismatch_d = mismatch_q;
      mismatch_c = mismatch_q | ((state_q == ST_PAY) && (s_axis.tdata != exp_byte_q));
      if (beat_c) begin
         if ((state_q == ST_SEQ) && (idx_q == IDX_W'(17))) exp_byte_d = s_axis.tdata;
         else if (state_q == ST_PAY)                       exp_byte_d = exp_byte_q + 8'd1;
         mismatch_d = last_c ? 1'b0 : mismatch_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_byte_q    <= '0;
         mismatch_q    <= 1'b0;
         bad_payload_q <= '0;
      end else begin
         exp_byte_q    <= exp_byte_d;
         mismatch_q    <= mismatch_d;
         bad_payload_q <= bad_payload_d;
      end
   end

   assign bad_payload = bad_payload_q;
`else
   assign mismatch_c  = 1'b0;
   assign bad_payload = '0;
`endif

   // Header / sequence parser
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      etype_d = etype_q;
      seq_d   = seq_q;
      if (beat_c) begin
         idx_d = last_c ? '0 : len_c;
         case (state_q)
            ST_HDR: begin
               if (idx_q == IDX_W'(12)) etype_d[15:8] = s_axis.tdata;
               if (idx_q == IDX_W'(13)) begin
                  etype_d[7:0] = s_axis.tdata;
                  state_d      = ST_SEQ;
               end
            end
            ST_SEQ: begin
               seq_d = {seq_q[SEQ_W-9:0], s_axis.tdata};
               if (idx_q == IDX_W'(17)) state_d = ST_PAY;
            end
            ST_PAY:  state_d = ST_PAY;
            default: state_d = ST_HDR;
         endcase
         if (last_c) state_d = ST_HDR;
      end
   end

   // Frame classification and statistics, applied on the tlast beat
   always_comb begin
      frame_done_d   = last_c;
      frame_good_d   = 1'b0;
      rx_frames_d    = rx_frames_q;
      rx_bytes_d     = rx_bytes_q;
      err_frames_d   = err_frames_q;
      other_frames_d = other_frames_q;
      good_frames_d  = good_frames_q;
      good_bytes_d   = good_bytes_q;
      lost_frames_d  = lost_frames_q;
      ooo_frames_d   = ooo_frames_q;
      seq_synced_d   = seq_synced_q;
      expected_d     = expected_q;
      seq_diff_c     = seq_cur_c - expected_q;
`ifdef RX_CHECKER_PAYLOAD_EN
      bad_payload_d  = bad_payload_q;
`endif
      if (last_c) begin
         rx_frames_d = sat_inc(rx_frames_q);
         rx_bytes_d  = sat_add_bytes(rx_bytes_q, len_c);
         if (frame_err_c) begin
            err_frames_d = sat_inc(err_frames_q);
         end else if (is_other_c) begin
            other_frames_d = sat_inc(other_frames_q);
         end else if (mismatch_c) begin
`ifdef RX_CHECKER_PAYLOAD_EN
            bad_payload_d = sat_inc(bad_payload_q);
`endif
         end else begin
            frame_good_d  = 1'b1;
            good_frames_d = sat_inc(good_frames_q);
            good_bytes_d  = sat_add_bytes(good_bytes_q, len_c);
            if (!seq_synced_q) begin
               seq_synced_d = 1'b1;
               expected_d   = seq_cur_c + SEQ_W'(1);
            end else if (seq_diff_c == '0) begin
               expected_d = seq_cur_c + SEQ_W'(1);
            end else if (!seq_diff_c[SEQ_W-1]) begin
               lost_frames_d = sat_add_lost(lost_frames_q, seq_diff_c);
               expected_d    = seq_cur_c + SEQ_W'(1);
            end else begin
               ooo_frames_d = sat_inc(ooo_frames_q);
            end
         end
      end
      // Clear beats a coincident update; the frame pulse itself still reports
      if (clear) begin
         rx_frames_d    = '0;
         rx_bytes_d     = '0;
         err_frames_d   = '0;
         other_frames_d = '0;
         good_frames_d  = '0;
         good_bytes_d   = '0;
         lost_frames_d  = '0;
         ooo_frames_d   = '0;
         seq_synced_d   = 1'b0;
         expected_d     = expected_q;
`ifdef RX_CHECKER_PAYLOAD_EN
         bad_payload_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HDR;
         idx_q          <= '0;
         etype_q        <= '0;
         seq_q          <= '0;
         frame_done_q   <= 1'b0;
         frame_good_q   <= 1'b0;
         rx_frames_q    <= '0;
         rx_bytes_q     <= '0;
         err_frames_q   <= '0;
         other_frames_q <= '0;
         good_frames_q  <= '0;
         good_bytes_q   <= '0;
         lost_frames_q  <= '0;
         ooo_frames_q   <= '0;
         seq_synced_q   <= 1'b0;
         expected_q     <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         etype_q        <= etype_d;
         seq_q          <= seq_d;
         frame_done_q   <= frame_done_d;
         frame_good_q   <= frame_good_d;
         rx_frames_q    <= rx_frames_d;
         rx_bytes_q     <= rx_bytes_d;
         err_frames_q   <= err_frames_d;
         other_frames_q <= other_frames_d;
         good_frames_q  <= good_frames_d;
         good_bytes_q   <= good_bytes_d;
         lost_frames_q  <= lost_frames_d;
         ooo_frames_q   <= ooo_frames_d;
         seq_synced_q   <= seq_synced_d;
         expected_q     <= expected_d;
      end
   end

   assign frame_done   = frame_done_q;
   assign frame_good   = frame_good_q;
   assign rx_frames    = rx_frames_q;
   assign rx_bytes     = rx_bytes_q;
   assign err_frames   = err_frames_q;
   assign other_frames = other_frames_q;
   assign good_frames  = good_frames_q;
   assign good_bytes   = good_bytes_q;
   assign lost_frames  = lost_frames_q;
   assign ooo_frames   = ooo_frames_q;
   assign seq_synced   = seq_synced_q;

endmodule
